k_wptr_full_ctrl_t1: RTL and testbench
======================================

K_WPTR_FULL_CTRL_T1 -- requirements
Module: k_wptr_full_ctrl_t1

Interface
REQ-001 Parameters SHALL be:
- addr_size, 4, RAM address width; depth len = 2^addr_size; legal range 2..12.
- afull_margin, 2, free-slot count at or below which walmost_full asserts; legal range 1..len-1.
REQ-002 Ports SHALL be:
- wclk, in, 1, write-domain clock.
- wrst, in, 1, reset.
- winc, in, 1, write request for the current cycle.
- wq2_rptr, in, addr_size+1, Gray read pointer, already two-flop synchronized into wclk.
- clr_ovf, in, 1, clears woverflow.
- wen, out, 1, RAM write enable.
- waddr, out, addr_size, RAM write address.
- wptr, out, addr_size+1, Gray write pointer, sent to the read-domain synchronizer.
- wfull, out, 1, FIFO full.
- walmost_full, out, 1, free slots <= afull_margin.
- wlevel, out, addr_size+1, occupied-slot count as seen from the write side.
- woverflow, out, 1, sticky: a write was attempted while full.
REQ-003 The block SHALL use one clock, wclk; reset wrst SHALL be synchronous and active-high.

Function
REQ-004 The block SHALL hold a registered binary pointer wbin (addr_size+1 bits) and a registered Gray pointer wptr; every register SHALL update on posedge wclk.
REQ-005 The write-accept term SHALL be acc = winc & !wfull; wen SHALL equal acc combinationally, with zero latency.
REQ-006 wbin_next SHALL equal wbin + acc, modulo 2^(addr_size+1); wgray_next SHALL equal (wbin_next >> 1) ^ wbin_next.
REQ-007 On each clock, wbin SHALL load wbin_next and wptr SHALL load wgray_next.
REQ-008 waddr SHALL equal wbin[addr_size-1:0] combinationally from the register, so that the RAM writes slot waddr in the same cycle wen is high.
REQ-009 wfull SHALL be registered and SHALL load (wgray_next == {~wq2_rptr[addr_size:addr_size-1], wq2_rptr[addr_size-2:0]}).
REQ-010 wfull SHALL deassert only through a change of wq2_rptr; it SHALL NOT deassert on its own timing.
REQ-011 rbin SHALL be the Gray-to-binary conversion of wq2_rptr (XOR prefix from the MSB).
REQ-012 wlevel SHALL be registered and SHALL load (wbin_next - rbin) modulo 2^(addr_size+1), with range 0..len.
REQ-013 wlevel SHALL be pessimistic, since the read pointer lags by the synchronizer delay; it SHALL never under-report occupancy.
REQ-014 walmost_full SHALL be registered and SHALL load ((len - wlevel_next) <= afull_margin).
REQ-015 Because REQ-014 is "less than or equal", walmost_full SHALL be high whenever wfull is high.
REQ-016 When winc & wfull, woverflow SHALL set on the next clock; the write SHALL be dropped, with wen low and the pointer held.
REQ-017 clr_ovf SHALL clear woverflow on the next clock.
REQ-018 When a set event and clr_ovf occur in the same cycle, set SHALL win.
REQ-019 Wrap-around: wbin SHALL roll from 2^(addr_size+1)-1 to 0, with no special-casing of the full or level computations.
REQ-020 A winc held high into the full condition SHALL be accepted on the cycle that fills the FIFO; wfull SHALL be high from the following cycle.

Reset
REQ-021 While wrst is high at posedge wclk, the block SHALL set wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0.
REQ-022 Reset SHALL take priority over winc and clr_ovf.
REQ-023 While wrst is high, wen SHALL be forced low.
REQ-024 A reset applied mid-stream SHALL discard the write-side state; read-side reset coordination belongs to the integrator.

Structure
REQ-025 Shared package k_fifo_pkg_t1 SHALL hold the bin2gray and gray2bin functions and the default addr_size, for reuse by the read-side controller.
REQ-026 One sub-module, k_gray2bin_t1 (parameterized width, combinational), SHALL convert wq2_rptr; all other logic SHALL reside in the top module.
REQ-027 The outputs waddr, wen, and wfull SHALL connect directly to the dual-port RAM's waddr, wen, and wfull inputs.

Verification
REQ-028 The bench SHALL use addr_size=4 (len=16), afull_margin=2, and wq2_rptr=0, and SHALL cover:
- Reset, then 16 consecutive winc: waddr sequence 0..15; wfull=1 after the 16th clock; wlevel=16; wptr=5'b11000.
- Full, then a 17th winc: wen=0; wptr unchanged; woverflow=1 next clock.
- clr_ovf and winc-while-full in the same cycle: woverflow stays 1.
- After 14 writes: walmost_full=1, wfull=0; after 13 writes: walmost_full=0.
- wq2_rptr advanced to Gray(8) while full: wfull=0 next clock; wlevel=8; 8 more writes re-fill.
- 40 writes interleaved with read-pointer advances across the 31->0 wrap: wlevel matches the model at every clock; no spurious wfull.
- wrst asserted while wfull=1 and winc=1: next clock all outputs are 0 and wen=0 during reset.

Source files
------------

// File: rtl/k_fifo_pkg_t1.sv
// Shared Gray/binary helpers and defaults for the FIFO write- and read-side pointer controllers.
package k_fifo_pkg_t1;

  localparam int unsigned ADDR_SIZE_DEFAULT = 4;
  // Widest pointer supported (addr_size up to 12, plus the wrap bit).
  localparam int unsigned PTR_W_MAX = 13;

  function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB, done in log2 steps; zero-extended inputs convert correctly.
  function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
    logic [PTR_W_MAX-1:0] b;
    b = g;
    for (int unsigned s = 1; s < PTR_W_MAX; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/k_gray2bin_t1.sv
// Combinational Gray-to-binary converter of parameterized width.
module k_gray2bin_t1
  import k_fifo_pkg_t1::*;
#(
  parameter int unsigned width = ADDR_SIZE_DEFAULT + 1
) (
  input  logic [width-1:0] gray_i,
  output logic [width-1:0] bin_o
);

  assign bin_o = width'(gray2bin(PTR_W_MAX'(gray_i)));

endmodule

// File: rtl/k_wptr_full_ctrl_t1.sv
// Write-side FIFO pointer controller: binary/Gray write pointer, full, almost-full,
// occupancy level and sticky overflow, all in the wclk domain.
module k_wptr_full_ctrl_t1
  import k_fifo_pkg_t1::*;
#(
  parameter int unsigned addr_size    = ADDR_SIZE_DEFAULT,
  parameter int unsigned afull_margin = 2
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 winc,
  input  logic [addr_size:0]   wq2_rptr,
  input  logic                 clr_ovf,
  output logic                 wen,
  output logic [addr_size-1:0] waddr,
  output logic [addr_size:0]   wptr,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [addr_size:0]   wlevel,
  output logic                 woverflow
);

  localparam int unsigned PW  = addr_size + 1;
  localparam int unsigned LEN = 1 << addr_size;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wgray_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_cmp;
  logic [PW:0]   free_d;
  logic          wfull_q, wfull_d;
  logic          wafull_q, wafull_d;
  logic          wovf_q, wovf_d;
  logic          acc;

  k_gray2bin_t1 #(.width(PW)) u_rptr_g2b (
    .gray_i (wq2_rptr),
    .bin_o  (rbin)
  );

  always_comb begin
    acc      = winc & ~wfull_q & ~wrst;
    wbin_d   = wbin_q + PW'(acc);
    wgray_d  = PW'(bin2gray(PTR_W_MAX'(wbin_d)));
    // Full when the next write pointer is exactly one lap ahead of the read pointer.
    full_cmp = {~wq2_rptr[addr_size -: 2], wq2_rptr[addr_size-2:0]};
    wfull_d  = (wgray_d == full_cmp);
    wlevel_d = wbin_d - rbin;
    free_d   = (PW+1)'(LEN) - {1'b0, wlevel_d};
    wafull_d = (free_d <= (PW+1)'(afull_margin));
    wovf_d   = (winc & wfull_q) | (wovf_q & ~clr_ovf);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wlevel_q <= '0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wgray_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wlevel_q <= wlevel_d;
      wovf_q   <= wovf_d;
    end
  end

  assign wen          = acc;
  assign waddr        = wbin_q[addr_size-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = wovf_q;

endmodule

// File: tb/tb_k_wptr_full_ctrl_t1.sv
// Scoreboard bench for the write-side pointer controller (addr_size=4, afull_margin=2).
module tb_k_wptr_full_ctrl_t1;

  logic       wclk = 1'b0;
  logic       wrst = 1'b1;
  logic       winc = 1'b0;
  logic [4:0] wq2_rptr = '0;
  logic       clr_ovf = 1'b0;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  k_wptr_full_ctrl_t1 #(.addr_size(4), .afull_margin(2)) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .clr_ovf      (clr_ovf),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       full;
    logic       afull;
    logic [4:0] level;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference state: plain binary write count and read position.
  int unsigned mw = 0;
  int unsigned mr = 0;
  logic        mfull = 1'b0;
  logic        mafull = 1'b0;
  int unsigned mlevel = 0;
  logic        movf = 1'b0;

  function automatic logic [4:0] to_gray(input int unsigned b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  // Apply one cycle of inputs at the negedge, push the expected outputs, advance the model.
  task automatic step(input logic inc, input int unsigned rb, input logic clr, input logic rst);
    exp_t e;
    logic acc;
    @(negedge wclk);
    winc = inc; clr_ovf = clr; wrst = rst;
    mr = rb & 31;
    wq2_rptr = to_gray(mr);
    acc = inc & ~mfull & ~rst;
    e.wen = acc;
    e.waddr = mw[3:0];
    e.wptr = to_gray(mw);
    e.full = mfull;
    e.afull = mafull;
    e.level = mlevel[4:0];
    e.ovf = movf;
    q.push_back(e);
    if (rst) begin
      mw = 0; mfull = 1'b0; mafull = 1'b0; mlevel = 0; movf = 1'b0;
    end else begin
      movf   = (inc & mfull) | (movf & ~clr);
      mw     = (mw + (acc ? 1 : 0)) & 31;
      mlevel = (mw - mr) & 31;
      mfull  = (mlevel == 16);
      mafull = ((16 - mlevel) <= 2);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge wclk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        vectors++;
        if ({wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow} !== e) begin
          miscompares++;
          $display("FAIL vec%0d got wen=%b waddr=%0d wptr=%b full=%b afull=%b level=%0d ovf=%b, need wen=%b waddr=%0d wptr=%b full=%b afull=%b level=%0d ovf=%b",
                   vectors, wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow,
                   e.wen, e.waddr, e.wptr, e.full, e.afull, e.level, e.ovf);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int unsigned rb;
    int guard;
    exp_t hand;
    repeat (2) @(posedge wclk);
    step(1'b1, 0, 1'b0, 1'b1);   // reset with winc high: wen must stay low
    step(1'b0, 0, 1'b0, 1'b1);

    // 16 writes fill the FIFO; waddr runs 0..15.
    for (int i = 0; i < 16; i++) step(1'b1, 0, 1'b0, 1'b0);
    // Hand-computed full state: wptr=11000, level=16, full and almost full.
    hand = '{wen: 1'b0, waddr: 4'd0, wptr: 5'b11000, full: 1'b1, afull: 1'b1, level: 5'd16, ovf: 1'b0};
    step(1'b1, 0, 1'b0, 1'b0);   // 17th write dropped
    if (q[q.size()-1] !== hand) begin
      miscompares++;
      $display("FAIL model_full_state model=%h hand=%h", q[q.size()-1], hand);
    end
    vectors++;
    step(1'b1, 0, 1'b1, 1'b0);   // set and clear together: set wins
    step(1'b0, 0, 1'b1, 1'b0);   // clear
    step(1'b0, 0, 1'b0, 1'b0);

    // Read side reaches 8 while full.
    step(1'b0, 8, 1'b0, 1'b0);
    step(1'b0, 8, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 8, 1'b0, 1'b0);
    step(1'b1, 8, 1'b0, 1'b0);
    step(1'b0, 8, 1'b0, 1'b0);

    // Almost-full threshold: 13 writes below it, 14 at it.
    step(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 13; i++) step(1'b1, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);

    // 40 writes with read advances across the pointer wrap.
    rb = 0;
    for (int i = 0; i < 48; i++) begin
      if (((mw - rb) & 31) > 10) rb = (rb + 1) & 31;
      step((i % 6) != 5, rb, 1'b0, 1'b0);
    end

    // Fill, then reset while full with winc high.
    guard = 0;
    while (!mfull && guard < 40) begin
      step(1'b1, rb, 1'b0, 1'b0);
      guard++;
    end
    step(1'b1, rb, 1'b0, 1'b1);
    step(1'b1, rb, 1'b0, 1'b1);
    step(1'b0, rb, 1'b0, 1'b0);
    step(1'b0, rb, 1'b0, 1'b0);

    guard = 0;
    while (q.size() != 0 && guard < 10) begin
      @(negedge wclk);
      guard++;
    end
    #5;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations unchecked, need 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
